// File: rtl/dmem_wb_bridge_if.sv
// Classic Wishbone master-side signal bundle between the dmem bridge and the data memory bus.
// The bridge drives cycle/strobe/address/data/select; the slave returns data, ack and err.
interface dmem_wb_bridge_if;
   logic        wb_cyc;
   logic        wb_stb;
   logic        wb_we;
   logic [3:0]  wb_sel;
   logic [31:0] wb_addr;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack;
   logic        wb_err;

   modport master (
      output wb_cyc, wb_stb, wb_we, wb_sel, wb_addr, wb_dat_o,
      input  wb_dat_i, wb_ack, wb_err
   );

   modport slave (
      input  wb_cyc, wb_stb, wb_we, wb_sel, wb_addr, wb_dat_o,
      output wb_dat_i, wb_ack, wb_err
   );
endinterface

// File: rtl/dmem_wb_bridge.sv
// Registered dmem-to-Wishbone bridge, one access at a time; resp >= 2 cycles after req (1 if misaligned).
// dmem_ready is low while a bus cycle or response is pending; requests seen then are dropped, not queued.
module dmem_wb_bridge #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TIMEOUT_W      = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    dmem_req,
   input  logic                    dmem_cmd,
   input  logic [1:0]              dmem_width,
   input  logic [31:0]             dmem_addr,
   input  logic [31:0]             dmem_wdata,
   output logic                    dmem_ready,
   output logic                    dmem_resp,
   output logic [31:0]             dmem_rdata,
   output logic                    dmem_err,
   dmem_wb_bridge_if.master        wb
);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   state_t               state;
   logic [TIMEOUT_W-1:0] cnt;
   logic [TIMEOUT_W-1:0] cnt_nxt;
   logic                 err_pend;
   logic [1:0]           width_q;
   logic [1:0]           ofs_q;
   logic                 misaligned;
   logic [3:0]           sel_c;
   logic [31:0]          dat_c;
   logic [31:0]          shifted;
   logic [31:0]          rdata_c;

   assign cnt_nxt = cnt + 1'b1;

   // Lane steering for the incoming request, evaluated only while idle.
   always_comb begin
      misaligned = 1'b0;
      sel_c      = 4'b0000;
      dat_c      = 32'h0;
      case (dmem_width)
         2'b00: begin
            sel_c = 4'b0001 << dmem_addr[1:0];
            dat_c = {24'h0, dmem_wdata[7:0]} << {dmem_addr[1:0], 3'b000};
         end
         2'b01: begin
            misaligned = dmem_addr[0];
            sel_c      = dmem_addr[1] ? 4'b1100 : 4'b0011;
            dat_c      = dmem_addr[1] ? {dmem_wdata[15:0], 16'h0} : {16'h0, dmem_wdata[15:0]};
         end
         2'b10: begin
            misaligned = |dmem_addr[1:0];
            sel_c      = 4'b1111;
            dat_c      = dmem_wdata;
         end
         default: misaligned = 1'b1;
      endcase
   end

   always_comb begin
      shifted = wb.wb_dat_i >> {ofs_q, 3'b000};
      case (width_q)
         2'b00:   rdata_c = {24'h0, shifted[7:0]};
         2'b01:   rdata_c = {16'h0, ofs_q[1] ? wb.wb_dat_i[31:16] : wb.wb_dat_i[15:0]};
         default: rdata_c = wb.wb_dat_i;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         err_pend     <= 1'b0;
         width_q      <= 2'b00;
         ofs_q        <= 2'b00;
         dmem_ready   <= 1'b1;
         dmem_resp    <= 1'b0;
         dmem_err     <= 1'b0;
         dmem_rdata   <= 32'h0;
         wb.wb_cyc    <= 1'b0;
         wb.wb_stb    <= 1'b0;
         wb.wb_we     <= 1'b0;
         wb.wb_sel    <= 4'b0000;
         wb.wb_addr   <= 32'h0;
         wb.wb_dat_o  <= 32'h0;
      end else begin
         dmem_resp <= 1'b0;
         dmem_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (dmem_req) begin
                  dmem_ready <= 1'b0;
                  width_q    <= dmem_width;
                  ofs_q      <= dmem_addr[1:0];
                  if (misaligned) begin
                     err_pend   <= 1'b1;
                     dmem_rdata <= 32'h0;
                     state      <= RESP;
                  end else begin
                     wb.wb_cyc   <= 1'b1;
                     wb.wb_stb   <= 1'b1;
                     wb.wb_we    <= dmem_cmd;
                     wb.wb_sel   <= sel_c;
                     wb.wb_addr  <= {dmem_addr[31:2], 2'b00};
                     wb.wb_dat_o <= dat_c;
                     cnt         <= '0;
                     state       <= BUS;
                  end
               end
            end
            BUS: begin
               cnt <= cnt_nxt;
               // err beats ack beats timeout when they coincide
               if (wb.wb_err || wb.wb_ack || cnt_nxt == TIMEOUT_W'(TIMEOUT_CYCLES)) begin
                  wb.wb_cyc  <= 1'b0;
                  wb.wb_stb  <= 1'b0;
                  state      <= RESP;
                  err_pend   <= wb.wb_err || !wb.wb_ack;
                  dmem_rdata <= (!wb.wb_err && wb.wb_ack && !wb.wb_we) ? rdata_c : 32'h0;
               end
            end
            RESP: begin
               dmem_resp  <= 1'b1;
               dmem_err   <= err_pend;
               dmem_ready <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_wb_bridge.sv
// Directed bench for dmem_wb_bridge with a response scoreboard; slave behaviour is scripted inline.
module tb_dmem_wb_bridge;
   logic        clk = 1'b0;
   logic        rst;
   logic        dmem_req;
   logic        dmem_cmd;
   logic [1:0]  dmem_width;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_ready;
   logic        dmem_resp;
   logic [31:0] dmem_rdata;
   logic        dmem_err;

   int checks = 0;
   int errors = 0;
   logic [32:0] exp_q[$];

   dmem_wb_bridge_if wb_if();

   dmem_wb_bridge #(.TIMEOUT_CYCLES(4), .TIMEOUT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .dmem_req   (dmem_req),
      .dmem_cmd   (dmem_cmd),
      .dmem_width (dmem_width),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_ready (dmem_ready),
      .dmem_resp  (dmem_resp),
      .dmem_rdata (dmem_rdata),
      .dmem_err   (dmem_err),
      .wb         (wb_if)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one request for a single cycle; optionally record the expected response.
   task automatic issue(input logic cmd, input logic [1:0] width, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit push, input logic err, input logic [31:0] rdata);
      check1("ready_before_req", dmem_ready, 1'b1);
      dmem_req   = 1'b1;
      dmem_cmd   = cmd;
      dmem_width = width;
      dmem_addr  = addr;
      dmem_wdata = wdata;
      if (push) exp_q.push_back({err, rdata});
      step();
      dmem_req = 1'b0;
   endtask

   task automatic check_bus(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                            input logic [31:0] dat);
      check1("wb_cyc", wb_if.wb_cyc, 1'b1);
      check1("wb_stb", wb_if.wb_stb, 1'b1);
      check1("wb_we", wb_if.wb_we, we);
      check4("wb_sel", wb_if.wb_sel, sel);
      check32("wb_addr", wb_if.wb_addr, addr);
      check32("wb_dat_o", wb_if.wb_dat_o, dat);
      check1("ready_busy", dmem_ready, 1'b0);
   endtask

   task automatic slave_reply(input logic ack, input logic err, input logic [31:0] dat);
      wb_if.wb_ack   = ack;
      wb_if.wb_err   = err;
      wb_if.wb_dat_i = dat;
      step();
      wb_if.wb_ack   = 1'b0;
      wb_if.wb_err   = 1'b0;
      wb_if.wb_dat_i = 32'h0;
      check1("cyc_dropped", wb_if.wb_cyc, 1'b0);
      check1("stb_dropped", wb_if.wb_stb, 1'b0);
   endtask

   // Wait (bounded) for the response pulse and compare against the oldest expectation.
   task automatic wait_resp(input int exp_lat);
      int n = 0;
      logic [32:0] e;
      while (dmem_resp !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      check1("resp_seen", dmem_resp, 1'b1);
      check32("resp_latency", 32'(n), 32'(exp_lat));
      if (dmem_resp === 1'b1) begin
         if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL unexpected_resp: observed resp with empty scoreboard, required none");
         end else begin
            e = exp_q.pop_front();
            check32("rdata", dmem_rdata, e[31:0]);
            check1("err", dmem_err, e[32]);
         end
      end
   endtask

   task automatic after_resp();
      step();
      check1("resp_one_cycle", dmem_resp, 1'b0);
      check1("ready_after_resp", dmem_ready, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      rst            = 1'b1;
      dmem_req       = 1'b0;
      dmem_cmd       = 1'b0;
      dmem_width     = 2'b00;
      dmem_addr      = 32'h0;
      dmem_wdata     = 32'h0;
      wb_if.wb_ack   = 1'b0;
      wb_if.wb_err   = 1'b0;
      wb_if.wb_dat_i = 32'h0;
      step();
      step();
      check1("rst_ready", dmem_ready, 1'b1);
      check1("rst_resp", dmem_resp, 1'b0);
      check1("rst_err", dmem_err, 1'b0);
      check1("rst_cyc", wb_if.wb_cyc, 1'b0);
      check1("rst_stb", wb_if.wb_stb, 1'b0);
      check1("rst_we", wb_if.wb_we, 1'b0);
      check4("rst_sel", wb_if.wb_sel, 4'b0000);
      check32("rst_rdata", dmem_rdata, 32'h0);
      check32("rst_addr", wb_if.wb_addr, 32'h0);
      check32("rst_dat_o", wb_if.wb_dat_o, 32'h0);
      rst = 1'b0;
      step();

      // Word load with an immediate ack
      issue(1'b0, 2'b10, 32'h0000_1000, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF);
      check_bus(1'b0, 4'b1111, 32'h0000_1000, 32'h0);
      slave_reply(1'b1, 1'b0, 32'hDEAD_BEEF);
      check1("resp_not_early", dmem_resp, 1'b0);
      wait_resp(1);
      after_resp();

      // Byte store to the top lane
      issue(1'b1, 2'b00, 32'h0000_2003, 32'h0000_00A5, 1'b1, 1'b0, 32'h0);
      check_bus(1'b1, 4'b1000, 32'h0000_2000, 32'hA500_0000);
      slave_reply(1'b1, 1'b0, 32'hFFFF_FFFF);
      wait_resp(1);
      after_resp();

      // Half load, upper lane
      issue(1'b0, 2'b01, 32'h0000_3002, 32'h0, 1'b1, 1'b0, 32'h0000_1234);
      check_bus(1'b0, 4'b1100, 32'h0000_3000, 32'h0);
      slave_reply(1'b1, 1'b0, 32'h1234_5678);
      wait_resp(1);
      after_resp();

      // Stray ack/err while idle must be ignored
      wb_if.wb_ack = 1'b1;
      wb_if.wb_err = 1'b1;
      step();
      wb_if.wb_ack = 1'b0;
      wb_if.wb_err = 1'b0;
      check1("idle_ack_no_resp", dmem_resp, 1'b0);
      check1("idle_ack_ready", dmem_ready, 1'b1);

      // Misaligned half load: no bus cycle, error response next cycle
      issue(1'b0, 2'b01, 32'h0000_3003, 32'h0, 1'b1, 1'b1, 32'h0);
      check1("misalign_no_cyc", wb_if.wb_cyc, 1'b0);
      check1("misalign_ready", dmem_ready, 1'b0);
      wait_resp(1);
      check1("misalign_still_no_cyc", wb_if.wb_cyc, 1'b0);
      after_resp();

      // Byte load from lane 1
      issue(1'b0, 2'b00, 32'h0000_4001, 32'h0, 1'b1, 1'b0, 32'h0000_0033);
      check_bus(1'b0, 4'b0010, 32'h0000_4000, 32'h0);
      slave_reply(1'b1, 1'b0, 32'h1122_3344);
      wait_resp(1);
      after_resp();

      // Half store to the upper lane
      issue(1'b1, 2'b01, 32'h0000_5002, 32'hFFFF_BEEF, 1'b1, 1'b0, 32'h0);
      check_bus(1'b1, 4'b1100, 32'h0000_5000, 32'hBEEF_0000);
      slave_reply(1'b1, 1'b0, 32'h0);
      wait_resp(1);
      after_resp();

      // Illegal width and misaligned word both rejected
      issue(1'b0, 2'b11, 32'h0000_6000, 32'h0, 1'b1, 1'b1, 32'h0);
      check1("width11_no_cyc", wb_if.wb_cyc, 1'b0);
      wait_resp(1);
      after_resp();
      issue(1'b1, 2'b10, 32'h0000_6002, 32'h1, 1'b1, 1'b1, 32'h0);
      check1("word_misalign_no_cyc", wb_if.wb_cyc, 1'b0);
      wait_resp(1);
      after_resp();

      // Timeout: cyc held exactly TIMEOUT_CYCLES cycles
      issue(1'b0, 2'b10, 32'h0000_7000, 32'h0, 1'b1, 1'b1, 32'h0);
      n = 0;
      while (wb_if.wb_cyc === 1'b1 && n < 50) begin
         n++;
         step();
      end
      check32("timeout_cyc_cycles", 32'(n), 32'd4);
      check1("timeout_stb_low", wb_if.wb_stb, 1'b0);
      wait_resp(1);
      after_resp();

      // ack and err together: err wins
      issue(1'b0, 2'b10, 32'h0000_8000, 32'h0, 1'b1, 1'b1, 32'h0);
      check_bus(1'b0, 4'b1111, 32'h0000_8000, 32'h0);
      slave_reply(1'b1, 1'b1, 32'h5555_5555);
      wait_resp(1);
      after_resp();

      // Reset mid-cycle: bus aborted, never responded
      issue(1'b0, 2'b10, 32'h0000_9000, 32'h0, 1'b0, 1'b0, 32'h0);
      check1("pre_rst_cyc", wb_if.wb_cyc, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check1("rst_bus_cyc", wb_if.wb_cyc, 1'b0);
      check1("rst_bus_stb", wb_if.wb_stb, 1'b0);
      check1("rst_bus_ready", dmem_ready, 1'b1);
      for (int i = 0; i < 3; i++) begin
         wb_if.wb_ack = (i == 0);
         step();
         check1("rst_bus_no_resp", dmem_resp, 1'b0);
      end
      wb_if.wb_ack = 1'b0;
      issue(1'b0, 2'b10, 32'h0000_A000, 32'h0, 1'b1, 1'b0, 32'h0BAD_CAFE);
      check_bus(1'b0, 4'b1111, 32'h0000_A000, 32'h0);
      slave_reply(1'b1, 1'b0, 32'h0BAD_CAFE);
      wait_resp(1);
      after_resp();

      // Request held high through BUS: only the first is serviced until ready returns
      check1("ready_before_held", dmem_ready, 1'b1);
      dmem_req   = 1'b1;
      dmem_cmd   = 1'b0;
      dmem_width = 2'b10;
      dmem_addr  = 32'h0000_B000;
      exp_q.push_back({1'b0, 32'h1111_2222});
      step();
      dmem_addr = 32'h0000_C000;
      check_bus(1'b0, 4'b1111, 32'h0000_B000, 32'h0);
      step();
      check_bus(1'b0, 4'b1111, 32'h0000_B000, 32'h0);
      slave_reply(1'b1, 1'b0, 32'h1111_2222);
      wait_resp(1);
      check1("held_ready_at_resp", dmem_ready, 1'b1);
      exp_q.push_back({1'b0, 32'h3333_4444});
      step();
      dmem_req = 1'b0;
      check_bus(1'b0, 4'b1111, 32'h0000_C000, 32'h0);
      slave_reply(1'b1, 1'b0, 32'h3333_4444);
      wait_resp(1);
      after_resp();

      check32("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/dmem_wb_bridge.md
Name: dmem_wb_bridge

Overview:
- Converts the core's data-memory port (req/cmd/width/addr/wdata, resp/rdata/err) into a classic Wishbone master cycle on the data memory bus.
- Sits between the superscalar core's dmem port and the second-memory Wishbone interface.
- Handles byte-lane steering for stores, lane extraction for loads, misalignment rejection and a bus timeout.
- Replaces the combinational select-only translation with a registered, one-transaction-at-a-time bridge.

Parameters:
- TIMEOUT_CYCLES, 255: cycles waited for ack/err before the access is aborted with an error. Legal range is 1 to 2^TIMEOUT_W-1.
- TIMEOUT_W, 8: width of the timeout counter.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- dmem_req  in  1  access request; sampled only when dmem_ready=1
- dmem_cmd  in  1  1=store, 0=load
- dmem_width  in  2  00=byte, 01=half, 10=word, 11=illegal
- dmem_addr  in  32  byte address
- dmem_wdata  in  32  store data, right-justified
- dmem_ready  out  1  bridge idle and able to accept a request
- dmem_resp  out  1  one-cycle completion pulse
- dmem_rdata  out  32  load data, right-justified, zero-extended; valid with dmem_resp
- dmem_err  out  1  error flag; valid with dmem_resp
- wb_cyc  out  1  Wishbone cycle
- wb_stb  out  1  Wishbone strobe
- wb_we  out  1  Wishbone write enable
- wb_sel  out  4  byte selects
- wb_addr  out  32  word-aligned address ({dmem_addr[31:2],2'b00})
- wb_dat_o  out  32  lane-steered write data
- wb_dat_i  in  32  read data
- wb_ack  in  1  transfer acknowledge
- wb_err  in  1  bus error

Behaviour:
- Reset (synchronous, active-high; applied at the next edge, including mid-transaction):
  - dmem_ready=1; dmem_resp, dmem_err, wb_cyc, wb_stb, wb_we = 0.
  - wb_sel=0; dmem_rdata, wb_addr, wb_dat_o = 0; state=IDLE; timeout counter=0.
  - An aborted bus cycle is not responded to.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - dmem_ready=1.
  - On dmem_req, latch cmd/width/addr/wdata.
  - Misaligned requests go to RESP with err=1 and generate no bus cycle. Misaligned means: half with addr[0]=1, word with addr[1:0]!=0, or width=11.
  - Any other request goes to BUS with wb_cyc=wb_stb=1 starting the next cycle.
  - wb_ack/wb_err arriving while IDLE are ignored.
- BUS:
  - wb_cyc and wb_stb are held high until termination.
  - The counter increments each cycle spent in BUS.
  - On wb_err: drop cyc/stb and go to RESP with err=1.
  - Else on wb_ack: drop cyc/stb, capture the extracted read data and go to RESP with err=0.
  - Else if counter reaches TIMEOUT_CYCLES: drop cyc/stb and go to RESP with err=1.
  - Priority when signals coincide: err > ack > timeout.
- RESP:
  - dmem_resp=1 for exactly one cycle; dmem_err as determined; then IDLE.
  - dmem_ready=0 in BUS and RESP; dmem_req asserted there is ignored, not queued.
- Latency:
  - Request sampled at edge N gives cyc/stb high after N.
  - If ack is sampled at edge N+1, dmem_resp is high after edge N+2.
  - Minimum 2 cycles from request to resp.
  - A misaligned request gives resp after edge N+1.
- wb_sel:
  - byte: 0001<<addr[1:0].
  - half: 0011 (addr[1]=0) or 1100 (addr[1]=1).
  - word: 1111.
  - wb_sel is driven for loads too.
- wb_dat_o:
  - byte: wdata[7:0] placed in lane addr[1:0].
  - half: wdata[15:0] placed in lane addr[1].
  - word: unchanged.
  - Unselected lanes = 0.
- dmem_rdata:
  - byte: wb_dat_i>>(8*addr[1:0]) masked to 8 bits.
  - half: wb_dat_i>>(16*addr[1]) masked to 16 bits.
  - word: unchanged.
  - On a store or on error, dmem_rdata=0.
- wb_we = latched cmd, held constant for the whole cycle.
- All address, select and data outputs are stable while cyc=1.

Test Plan:
- Word load at 0x0000_1000; slave acks 1 cycle after stb with 0xDEADBEEF -> wb_addr=0x1000, sel=1111, we=0; resp pulse 1 cycle with rdata=0xDEADBEEF, err=0; ready high the cycle after resp.
- Byte store 0xA5 at 0x0000_2003 -> sel=1000, wb_dat_o=0xA500_0000, we=1, wb_addr=0x2000; after ack, resp=1, err=0, rdata=0.
- Half load at 0x0000_3002; slave returns 0x1234_5678 -> sel=1100, rdata=0x0000_1234; the same access at 0x3003 -> no cyc asserted, resp next cycle with err=1.
- No ack with TIMEOUT_CYCLES=4 -> cyc/stb high exactly 4 cycles, then dropped; resp with err=1. Separately, ack and err in the same cycle -> err=1.
- rst asserted while in BUS -> cyc/stb=0 after the edge, no resp; a new word load right after reset completes normally. A second dmem_req held high during BUS is not serviced until ready=1.
